// File: rtl/mips_alu.sv
// mips_alu: registered integer ALU for the MIPS EX stage.
// The result is captured on the rising edge of clk, and Zero is decoded from
// that registered result.
// Optional feature (macro ALU_OVERFLOW_EN): adds a registered Overflow output
// that flags signed overflow on ADD and SUB.
module mips_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] ALU_operand_1,
   input  logic [WIDTH-1:0] ALU_operand_2,
   input  logic [3:0]       ALU_ctrl_input,
`ifdef ALU_OVERFLOW_EN
   output logic             Overflow,
`endif
   output logic [WIDTH-1:0] ALU_result,
   output logic             Zero
);

   localparam int SHW  = $clog2(WIDTH);
   localparam int HALF = WIDTH / 2;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_ADD  = 4'b0110;
   localparam logic [3:0] OP_SLTU = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_LUI  = 4'b1011;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             sign_a;
   logic             sign_b;
   logic             slt_bit;
   logic             sltu_bit;
   logic [WIDTH-1:0] next_result;

   assign op_a   = ALU_operand_1;
   assign op_b   = ALU_operand_2;
   assign shamt  = op_b[SHW-1:0];
   assign sign_a = op_a[WIDTH-1];
   assign sign_b = op_b[WIDTH-1];

   // Wrapping adder and subtractor; carries out of the MSB are dropped.
   always_comb begin
      sum  = op_a + op_b;
      diff = op_a - op_b;
   end

   // Set-less-than decisions. When the operand signs differ the truncated
   // difference may have overflowed, so A's sign alone decides the signed
   // compare; with equal signs the subtraction cannot overflow.
   always_comb begin
      if (sign_a != sign_b) begin
         slt_bit = sign_a;
      end else begin
         slt_bit = diff[WIDTH-1];
      end
      sltu_bit = (op_a < op_b);
   end

   // Operation select; reserved and unknown codes fall through to zero.
   always_comb begin
      next_result = '0;
      case (ALU_ctrl_input)
         OP_AND:  next_result = op_a & op_b;
         OP_OR:   next_result = op_a | op_b;
         OP_SUB:  next_result = diff;
         OP_XOR:  next_result = op_a ^ op_b;
         OP_NOR:  next_result = ~(op_a | op_b);
         OP_SLT:  next_result = {{(WIDTH-1){1'b0}}, slt_bit};
         OP_ADD:  next_result = sum;
         OP_SLTU: next_result = {{(WIDTH-1){1'b0}}, sltu_bit};
         OP_SLL:  next_result = op_a << shamt;
         OP_SRL:  next_result = op_a >> shamt;
         OP_SRA:  next_result = WIDTH'($signed(op_a) >>> shamt);
         OP_LUI:  next_result = op_b << HALF;
         default: next_result = '0;
      endcase
   end

`ifdef ALU_OVERFLOW_EN
   logic next_overflow;

   // Signed overflow: operands of like sign (ADD) or unlike sign (SUB)
   // producing a result whose sign differs from A.
   always_comb begin
      next_overflow = 1'b0;
      case (ALU_ctrl_input)
         OP_ADD:  next_overflow = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a);
         OP_SUB:  next_overflow = (sign_a != sign_b) && (diff[WIDTH-1] != sign_a);
         default: next_overflow = 1'b0;
      endcase
   end

   // Overflow is registered alongside the result so both describe the same op.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Overflow <= 1'b0;
      end else begin
         Overflow <= next_overflow;
      end
   end
`endif

   // Result register; reset clears it asynchronously and drops any pending op.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ALU_result <= '0;
      end else begin
         ALU_result <= next_result;
      end
   end

   // Zero is decoded from the registered result so it can never disagree with it.
   assign Zero = (ALU_result == '0);

endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: scoreboard bench for mips_alu (WIDTH = 8).
// Stimulus pushes expected responses; a monitor pops one per clock edge.
module tb_mips_alu;

   localparam int W = 8;
   localparam int M = 1 << W;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [3:0]   ctrl;
   logic [W-1:0] result;
   logic         zero;
`ifdef ALU_OVERFLOW_EN
   logic         ovf;
`endif

   mips_alu #(.WIDTH(W)) dut (
      .clk            (clk),
      .reset          (reset),
      .ALU_operand_1  (op_a),
      .ALU_operand_2  (op_b),
      .ALU_ctrl_input (ctrl),
`ifdef ALU_OVERFLOW_EN
      .Overflow       (ovf),
`endif
      .ALU_result     (result),
      .Zero           (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      int r;
      int o;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passes = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic int sx(input int v);
      return (v >= M / 2) ? v - M : v;
   endfunction

   // Reference model from the operation definitions, in plain integer arithmetic.
   function automatic exp_t model(input int a, input int b, input int c);
      exp_t e;
      int   sh;
      int   s;
      sh  = b % W;
      e.o = 0;
      case (c)
         0:  e.r = a & b;
         1:  e.r = a | b;
         2:  begin s = sx(a) - sx(b); e.r = (a - b + M) % M; e.o = (s < -M/2 || s > M/2 - 1) ? 1 : 0; end
         3:  e.r = a ^ b;
         4:  e.r = (M - 1) - (a | b);
         5:  e.r = (sx(a) < sx(b)) ? 1 : 0;
         6:  begin s = sx(a) + sx(b); e.r = (a + b) % M; e.o = (s < -M/2 || s > M/2 - 1) ? 1 : 0; end
         7:  e.r = (a < b) ? 1 : 0;
         8:  e.r = (a * (1 << sh)) % M;
         9:  e.r = a / (1 << sh);
         10: e.r = (sx(a) >>> sh) & (M - 1);
         11: e.r = (b * (1 << (W / 2))) % M;
         default: e.r = 0;
      endcase
      return e;
   endfunction

   task automatic drive(input int a, input int b, input int c);
      @(negedge clk);
      op_a = W'(a);
      op_b = W'(b);
      ctrl = 4'(c);
   endtask

   task automatic issue_model(input int a, input int b, input int c);
      drive(a, b, c);
      q.push_back(model(a, b, c));
   endtask

   task automatic issue_exp(input int a, input int b, input int c, input int r, input int o);
      exp_t e;
      drive(a, b, c);
      e.r = r;
      e.o = o;
      q.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      #2;
      check("drain_queue_empty", q.size(), 0);
   endtask

   // Monitor: one registered response per rising edge while work is outstanding.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("result", int'(result), e.r);
            check("zero", int'(zero), (e.r == 0) ? 1 : 0);
`ifdef ALU_OVERFLOW_EN
            check("overflow", int'(ovf), e.o);
`endif
         end
      end
   end

   initial begin
      int a;
      int b;
      int c;
      exp_t e;
      op_a = '0;
      op_b = '0;
      ctrl = '0;
      #12;
      check("reset_result", int'(result), 0);
      check("reset_zero", int'(zero), 1);
`ifdef ALU_OVERFLOW_EN
      check("reset_overflow", int'(ovf), 0);
`endif
      @(negedge clk);
      reset = 1'b0;

      issue_exp(15, 10, 4'b0110, 25, 0);
      issue_exp(10, 10, 4'b0010, 0, 0);
      issue_exp('hF0, 'h0F, 4'b0000, 0, 0);
      issue_exp('hF0, 'h0F, 4'b0001, 'hFF, 0);
      issue_exp('hF0, 'h0F, 4'b0100, 'h00, 0);
      issue_exp('hFF, 'h01, 4'b0101, 1, 0);
      issue_exp('hFF, 'h01, 4'b0111, 0, 0);
      issue_exp('h80, 'h7F, 4'b0101, 1, 0);
      issue_exp('h7F, 'h80, 4'b0101, 0, 0);
      issue_exp('h81, 3, 4'b1000, 'h08, 0);
      issue_exp('h81, 3, 4'b1001, 'h10, 0);
      issue_exp('h81, 3, 4'b1010, 'hF0, 0);
      issue_exp('h81, 'h0B, 4'b1000, 'h08, 0);
      issue_exp('h00, 'hA5, 4'b1011, 'h50, 0);
      issue_exp('h7F, 'h01, 4'b0110, 'h80, 1);
      issue_exp('h80, 'h01, 4'b0010, 'h7F, 1);
      issue_exp('h33, 'h55, 4'b1111, 0, 0);
      issue_exp('h33, 'h55, 4'b1100, 0, 0);
      issue_exp(1, 1, 4'b0110, 2, 0);
      drain();

      // Asynchronous reset mid-cycle discards the pending ADD.
      drive(15, 10, 4'b0110);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_result", int'(result), 0);
      check("async_reset_zero", int'(zero), 1);
      @(posedge clk);
      #1;
      check("held_reset_result", int'(result), 0);
      @(negedge clk);
      reset = 1'b0;
      e.r = 25;
      e.o = 0;
      q.push_back(e);
      drain();

      repeat (400) begin
         c = $urandom_range(0, 15);
         case ($urandom_range(0, 3))
            0:       a = ($urandom_range(0, 1) != 0) ? 'h7F : 'h80;
            default: a = $urandom_range(0, M - 1);
         endcase
         case ($urandom_range(0, 3))
            0:       b = ($urandom_range(0, 1) != 0) ? 'hFF : 'h01;
            default: b = $urandom_range(0, M - 1);
         endcase
         issue_model(a, b, c);
      end
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- Registered integer ALU for the EX stage of the MIPS pipeline.
- Combines two operands under a 4-bit ALU control code from the ALU-control decoder.
- Result and zero flag are captured on the rising clock edge and held stable for the EX/MEM pipeline register and branch logic.

Parameters:
- WIDTH, 8, operand and result width in bits; legal values are 8, 16 or 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ALU_operand_1  input  WIDTH  operand A (rs value).
- ALU_operand_2  input  WIDTH  operand B (rt value or immediate; shift amount for shifts).
- ALU_ctrl_input  input  4  operation select.
- ALU_result  output  WIDTH  registered result.
- Zero  output  1  high when ALU_result is all zeros.

Behaviour:
- Reset: asserting reset immediately forces ALU_result to 0, independent of clk. Zero therefore reads 1.
- Reset mid-operation: discards the pending result. The first capture after reset deasserts is at the next rising edge.
- Latency: exactly 1 cycle.
  - Inputs sampled at rising edge N appear on ALU_result at edge N (after clock-to-q).
  - Outputs hold until the next edge.
  - No handshake; a new operation may be issued every cycle.
- Zero: combinational decode of the registered ALU_result. It is never registered separately, so it is always consistent with ALU_result.
- Operations (A = ALU_operand_1, B = ALU_operand_2):
  - 0000 AND: A & B
  - 0001 OR: A | B
  - 0010 SUB: A - B, modulo 2^WIDTH
  - 0011 XOR: A ^ B
  - 0100 NOR: ~(A | B)
  - 0101 SLT: 1 if signed(A) < signed(B), else 0
  - 0110 ADD: A + B, modulo 2^WIDTH
  - 0111 SLTU: 1 if unsigned A < unsigned B, else 0
  - 1000 SLL: A << shamt
  - 1001 SRL: A >> shamt, zero fill
  - 1010 SRA: A >>> shamt, sign fill
  - 1011 LUI-style: B << (WIDTH/2)
  - 1100–1111: reserved; result 0.
- shamt = low log2(WIDTH) bits of B. Upper bits of B are ignored for shifts.
- Arithmetic: carries out of the MSB are discarded. Add and subtract wrap with no saturation.
- SLT/SLTU write 1 into bit 0 and zeros into all other bits.
- SLT must be correct across signed overflow: compare using the sign of the true difference, not the truncated difference.
- X or undefined control codes are treated as reserved.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined:
  - Adds output port Overflow (1 bit), registered alongside ALU_result.
  - Overflow = 1 when ADD or SUB produces two's-complement signed overflow; 0 for every other op.
  - Reset value is 0.
- Undefined:
  - The port does not exist.
  - Overflow is silently ignored (wrap-around only).

Test Plan:
- A=15, B=10, ctrl=0110 → after next rising edge ALU_result=25, Zero=0.
- A=10, B=10, ctrl=0010 → ALU_result=0, Zero=1; then ctrl=0000 with A=0xF0, B=0x0F → 0x00, Zero=1.
- A=0xFF (-1), B=0x01, ctrl=0101 → 1; same operands with ctrl=0111 → 0. A=0x80, B=0x7F, ctrl=0101 → 1.
- A=0x81, B=3: ctrl=1000 → 0x08; ctrl=1001 → 0x10; ctrl=1010 → 0xF0. B=0x0B (shamt 3), ctrl=1000 → 0x08.
- Issue ADD 15+10, assert reset asynchronously mid-cycle → ALU_result=0 and Zero=1 immediately. Release reset; the next edge captures the current inputs.
- With ALU_OVERFLOW_EN: A=0x7F, B=0x01, ctrl=0110 → ALU_result=0x80, Overflow=1. Reserved ctrl=1111 → ALU_result=0, Overflow=0.
